// File: rtl/pmem_burst_bridge_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types (pmem burst bridge slice)
//
// Purpose : shared types for the cache-side physical-memory line interface
//           and the 64-bit burst bridge that serves it.
// Contents: pmem_line_t         - one 256-bit cache line (byte 0 in [7:0])
//           pmem_beat_t         - one 64-bit downstream beat
//           pmem_bridge_state_t - bridge FSM states
//           PMEM_BEATS / PMEM_BEAT_IDX_W - beats per line and index width
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef logic [255:0] pmem_line_t;
   typedef logic [63:0]  pmem_beat_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } pmem_bridge_state_t;

   localparam int unsigned PMEM_BEATS      = 4;
   localparam int unsigned PMEM_BEAT_IDX_W = 2;

endpackage

// File: rtl/burst_line_buffer.sv
// -----------------------------------------------------------------------------
// burst_line_buffer
//
// Purpose : one 256-bit line register that can be loaded whole (write
//           capture) or one 64-bit lane at a time (read assembly), with a
//           combinational lane-select output for streaming write beats.
// Ports   : clk, reset    - clock, asynchronous active-high reset
//           load_line_i   - load line_i into the whole register
//           line_i        - full line to capture
//           load_lane_i   - load lane_i into lane lane_idx_i
//           lane_idx_i    - lane written by load_lane_i
//           lane_i        - beat data for the lane load
//           sel_idx_i     - lane presented on lane_o
//           line_o        - registered line contents
//           lane_o        - lane sel_idx_i of the register (combinational)
// -----------------------------------------------------------------------------
module burst_line_buffer
   import rv32i_types::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_line_i,
   input  pmem_line_t                 line_i,
   input  logic                       load_lane_i,
   input  logic [PMEM_BEAT_IDX_W-1:0] lane_idx_i,
   input  pmem_beat_t                 lane_i,
   input  logic [PMEM_BEAT_IDX_W-1:0] sel_idx_i,
   output pmem_line_t                 line_o,
   output pmem_beat_t                 lane_o
);

   pmem_line_t data_q;

   // NOTE: this line store is a plain register, not a RAM, so it is cleared
   // by reset; that is what makes an aborted partial line read back as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else if (load_line_i) begin
         data_q <= line_i;
      end else if (load_lane_i) begin
         // Lane k occupies bits [64k+63 : 64k]; {idx, 6'b0} is 64*idx.
         data_q[{lane_idx_i, 6'b0} +: 64] <= lane_i;
      end
   end

   assign line_o = data_q;
   assign lane_o = data_q[{sel_idx_i, 6'b0} +: 64];

endmodule

// File: rtl/pmem_burst_bridge.sv
// -----------------------------------------------------------------------------
// pmem_burst_bridge
//
// Purpose : responder for the cache's 256-bit pmem line interface. Each line
//           read or write becomes four in-order 64-bit beats on the bmem
//           port; a single pmem_resp pulse completes the transaction.
// Ports   : clk, reset             - clock, asynchronous active-high reset
//           pmem_address[31:0]     - line address (bits [4:0] ignored)
//           pmem_read / pmem_write - line requests, held until pmem_resp
//           pmem_wdata[255:0]      - line to write
//           pmem_rdata[255:0]      - assembled read line (registered)
//           pmem_resp              - one-cycle completion pulse
//           bmem_address[31:0]     - beat address {line, beat, 3'b000}
//           bmem_read / bmem_write - beat requests
//           bmem_wdata[63:0]       - current write beat
//           bmem_rdata[63:0]       - read beat, valid with bmem_resp
//           bmem_resp              - beat completion, one pulse per beat
// -----------------------------------------------------------------------------
module pmem_burst_bridge
   import rv32i_types::*;
#(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_line   = 256,
   parameter int unsigned s_beat   = 64
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pmem_address,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic [31:0]       bmem_address,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [s_beat-1:0] bmem_wdata,
   input  logic [s_beat-1:0] bmem_rdata,
   input  logic              bmem_resp
);

   localparam int unsigned LINE_W = 32 - s_offset;
   localparam int unsigned BYTE_W = $clog2(s_beat / 8);
   localparam logic [PMEM_BEAT_IDX_W-1:0] LAST_BEAT = PMEM_BEAT_IDX_W'(PMEM_BEATS - 1);

   pmem_bridge_state_t          state_q, state_d;
   logic [PMEM_BEAT_IDX_W-1:0] beat_q, beat_d;
   logic [LINE_W-1:0]          line_q, line_d;

   logic wr_capture;   // load the whole write line on acceptance
   logic rd_lane_load; // store bmem_rdata into lane beat_q

   pmem_line_t unused_wr_line;
   pmem_beat_t unused_rd_lane;
   logic       unused_offset;

   // The line offset never reaches the downstream port.
   assign unused_offset = ^pmem_address[s_offset-1:0];

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      line_d       = line_q;
      wr_capture   = 1'b0;
      rd_lane_load = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Write takes priority; a simultaneous read waits for the cache
            // to present it again after this write completes.
            if (pmem_write) begin
               state_d    = WRITE;
               line_d     = pmem_address[31:s_offset];
               beat_d     = '0;
               wr_capture = 1'b1;
            end else if (pmem_read) begin
               state_d = READ;
               line_d  = pmem_address[31:s_offset];
               beat_d  = '0;
            end
         end
         READ: begin
            if (bmem_resp) begin
               rd_lane_load = 1'b1;
               beat_d       = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = RESP;
            end
         end
         WRITE: begin
            if (bmem_resp) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode straight from registered state, so reset clears them at
   // once without waiting for a clock edge.
   assign bmem_read    = (state_q == READ);
   assign bmem_write   = (state_q == WRITE);
   assign pmem_resp    = (state_q == RESP);
   assign bmem_address = {line_q, beat_q, {BYTE_W{1'b0}}};

   // Separate buffers keep pmem_rdata intact across write transactions.
   burst_line_buffer u_wr_buf (
      .clk         (clk),
      .reset       (reset),
      .load_line_i (wr_capture),
      .line_i      (pmem_wdata),
      .load_lane_i (1'b0),
      .lane_idx_i  ('0),
      .lane_i      ('0),
      .sel_idx_i   (beat_q),
      .line_o      (unused_wr_line),
      .lane_o      (bmem_wdata)
   );

   burst_line_buffer u_rd_buf (
      .clk         (clk),
      .reset       (reset),
      .load_line_i (1'b0),
      .line_i      ('0),
      .load_lane_i (rd_lane_load),
      .lane_idx_i  (beat_q),
      .lane_i      (bmem_rdata),
      .sel_idx_i   ('0),
      .line_o      (pmem_rdata),
      .lane_o      (unused_rd_lane)
   );

endmodule
